// File: rtl/bitwise_issue_ctrl_pkg.sv
// Shared definitions for the SCRISC-16 bitwise issue sequencer:
// FSM state encoding, funct codes, instruction field positions and defaults.
package bitwise_issue_ctrl_pkg;

    localparam logic [3:0] OPC_BITWISE_DEF = 4'b0010;
    localparam int         CNT_W_DEF       = 16;

    // funct codes understood by the bitwise unit
    localparam logic [1:0] FN_AND = 2'b00;
    localparam logic [1:0] FN_OR  = 2'b01;
    localparam logic [1:0] FN_XOR = 2'b10;
    localparam logic [1:0] FN_NOT = 2'b11;

    // instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int FN_MSB  = 1;
    localparam int FN_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/bitwise_issue_ctrl_if.sv
// Bus bundle between the issue sequencer (master) and its surroundings:
// instruction handshake, register-file reads, bitwise unit and write-back.
// Optional flag outputs exist only when BITWISE_FLAGS_EN is defined.
interface bitwise_issue_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [15:0]      instr;
    logic [2:0]       rs_addr;
    logic [2:0]       rt_addr;
    logic [15:0]      rs_data;
    logic [15:0]      rt_data;
    logic [15:0]      bw_a;
    logic [15:0]      bw_b;
    logic [1:0]       bw_funct;
    logic [15:0]      bw_out;
    logic             wb_valid;
    logic             wb_ready;
    logic [2:0]       wb_addr;
    logic [15:0]      wb_data;
    logic             illegal;
    logic [CNT_W-1:0] ops_done;
`ifdef BITWISE_FLAGS_EN
    logic             flag_z;
    logic             flag_n;

    modport master (
        input  instr_valid, instr, rs_data, rt_data, bw_out, wb_ready,
        output instr_ready, rs_addr, rt_addr, bw_a, bw_b, bw_funct,
               wb_valid, wb_addr, wb_data, illegal, ops_done, flag_z, flag_n
    );
    modport slave (
        output instr_valid, instr, rs_data, rt_data, bw_out, wb_ready,
        input  instr_ready, rs_addr, rt_addr, bw_a, bw_b, bw_funct,
               wb_valid, wb_addr, wb_data, illegal, ops_done, flag_z, flag_n
    );
`else
    modport master (
        input  instr_valid, instr, rs_data, rt_data, bw_out, wb_ready,
        output instr_ready, rs_addr, rt_addr, bw_a, bw_b, bw_funct,
               wb_valid, wb_addr, wb_data, illegal, ops_done
    );
    modport slave (
        output instr_valid, instr, rs_data, rt_data, bw_out, wb_ready,
        input  instr_ready, rs_addr, rt_addr, bw_a, bw_b, bw_funct,
               wb_valid, wb_addr, wb_data, illegal, ops_done
    );
`endif
endinterface

// File: rtl/bitwise_instr_fields.sv
// Combinational slicer of the 16-bit instruction word into its fields.
// Bit 2 of the word is reserved and not decoded.
module bitwise_instr_fields
    import bitwise_issue_ctrl_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic [3:0]  opcode_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rs_o,
    output logic [2:0]  rt_o,
    output logic [1:0]  funct_o
);
    assign opcode_o = instr_i[OPC_MSB:OPC_LSB];
    assign rd_o     = instr_i[RD_MSB:RD_LSB];
    assign rs_o     = instr_i[RS_MSB:RS_LSB];
    assign rt_o     = instr_i[RT_MSB:RT_LSB];
    assign funct_o  = instr_i[FN_MSB:FN_LSB];
endmodule

// File: rtl/bitwise_issue_ctrl.sv
// Issue sequencer for the 16-bit bitwise logic unit.
// One instruction in flight: IDLE -> READ -> EXEC -> WB (or ERR for a
// foreign opcode). rd=0 targets hardwired r0, so the write-back is skipped.
// Optional feature macro: BITWISE_FLAGS_EN adds zero/negative result flags.
module bitwise_issue_ctrl
    import bitwise_issue_ctrl_pkg::*;
#(
    parameter logic [3:0] OPC_BITWISE = OPC_BITWISE_DEF,
    parameter int         CNT_W       = CNT_W_DEF
) (
    input logic                  clk,
    input logic                  rst,
    bitwise_issue_ctrl_if.master bus
);
    state_t           state_q, state_d;
    logic [3:0]       opc;
    logic [2:0]       rd, rs, rt;
    logic [1:0]       fn;
    logic [2:0]       rd_q, rs_addr_q, rt_addr_q, wb_addr_q;
    logic [1:0]       funct_q, bw_funct_q;
    logic [15:0]      bw_a_q, bw_b_q;
    logic [CNT_W-1:0] ops_done_q;
    logic             accept, legal, wb_fire;

    bitwise_instr_fields u_fields (
        .instr_i  (bus.instr),
        .opcode_o (opc),
        .rd_o     (rd),
        .rs_o     (rs),
        .rt_o     (rt),
        .funct_o  (fn)
    );

    assign accept  = (state_q == S_IDLE) && bus.instr_valid;
    assign legal   = (opc == OPC_BITWISE);
    assign wb_fire = (state_q == S_WB) && bus.wb_ready;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = legal ? S_READ : S_ERR;
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = (rd_q == 3'd0) ? S_IDLE : S_WB;
            S_WB:   if (bus.wb_ready) state_d = S_IDLE;
            S_ERR:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state-decoded outputs; wb_data tracks the unit result while in WB
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.illegal     = 1'b0;
        bus.wb_data     = '0;
        case (state_q)
            S_IDLE: bus.instr_ready = 1'b1;
            S_WB: begin
                bus.wb_valid = 1'b1;
                bus.wb_data  = bus.bw_out;
            end
            S_ERR:  bus.illegal = 1'b1;
            default: ;
        endcase
    end

    // latch fields on a legal accept, capture RF data into operand regs in EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q       <= '0;
            funct_q    <= FN_AND;
            rs_addr_q  <= '0;
            rt_addr_q  <= '0;
            bw_a_q     <= '0;
            bw_b_q     <= '0;
            bw_funct_q <= FN_AND;
            wb_addr_q  <= '0;
        end else begin
            if (accept && legal) begin
                rd_q      <= rd;
                funct_q   <= fn;
                rs_addr_q <= rs;
                rt_addr_q <= rt;
            end
            if (state_q == S_EXEC) begin
                bw_a_q     <= bus.rs_data;
                bw_b_q     <= bus.rt_data;
                bw_funct_q <= funct_q;
                wb_addr_q  <= rd_q;
            end
        end
    end

    // saturating count of completed write-backs
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          ops_done_q <= '0;
        else if (wb_fire && !(&ops_done_q)) ops_done_q <= ops_done_q + 1'b1;
    end

    assign bus.rs_addr  = rs_addr_q;
    assign bus.rt_addr  = rt_addr_q;
    assign bus.bw_a     = bw_a_q;
    assign bus.bw_b     = bw_b_q;
    assign bus.bw_funct = bw_funct_q;
    assign bus.wb_addr  = wb_addr_q;
    assign bus.ops_done = ops_done_q;

`ifdef BITWISE_FLAGS_EN
    logic flag_z_q, flag_n_q, flag_pend_q;

    // flags follow the write-back result, or bw_out one cycle after EXEC for rd=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_pend_q <= 1'b0;
        end else begin
            flag_pend_q <= (state_q == S_EXEC) && (rd_q == 3'd0);
            if (wb_fire) begin
                flag_z_q <= (bus.wb_data == 16'h0000);
                flag_n_q <= bus.wb_data[15];
            end else if (flag_pend_q) begin
                flag_z_q <= (bus.bw_out == 16'h0000);
                flag_n_q <= bus.bw_out[15];
            end
        end
    end

    assign bus.flag_z = flag_z_q;
    assign bus.flag_n = flag_n_q;
`endif

endmodule

// File: tb/tb_bitwise_issue_ctrl.sv
// Directed bench for bitwise_issue_ctrl (CNT_W=4 build so saturation is reachable).
// Provides a synchronous-read register file and a behavioural bitwise unit.
module tb_bitwise_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] rf [8];

    always #5 clk = ~clk;

    bitwise_issue_ctrl_if #(.CNT_W(4)) bus ();

    bitwise_issue_ctrl #(.CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // register file: one-cycle synchronous read
    always @(posedge clk) begin
        bus.rs_data <= rf[bus.rs_addr];
        bus.rt_data <= rf[bus.rt_addr];
    end

    // external bitwise unit
    always_comb begin
        case (bus.bw_funct)
            2'b00:   bus.bw_out = bus.bw_a & bus.bw_b;
            2'b01:   bus.bw_out = bus.bw_a | bus.bw_b;
            2'b10:   bus.bw_out = bus.bw_a ^ bus.bw_b;
            default: bus.bw_out = ~bus.bw_a;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] opc, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt,
                                       input logic [1:0] fn);
        return {opc, rd, rs, rt, 1'b0, fn};
    endfunction

    task automatic issue(input logic [15:0] ins);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
    endtask

    // negedges after the accept edge until wb_valid (READ=1, EXEC=2, WB=3)
    task automatic wait_wb(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.wb_valid && k < 8);
    endtask

    task automatic op(input string tag, input logic [15:0] ins, input logic [2:0] ea,
                      input logic [15:0] ed, input logic [3:0] ecnt);
        int k;
        issue(ins);
        wait_wb(k);
        chk({tag, "_lat"}, k, 3);
        chk({tag, "_addr"}, bus.wb_addr, ea);
        chk({tag, "_data"}, bus.wb_data, ed);
        @(negedge clk);
        chk({tag, "_cnt"}, bus.ops_done, ecnt);
        chk({tag, "_idle"}, {bus.instr_ready, bus.wb_valid}, 2'b10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rf[0] = 16'h0000; rf[1] = 16'hF0F0; rf[2] = 16'h3C3C; rf[3] = 16'h1234;
        rf[4] = 16'h00FF; rf[5] = 16'h0000; rf[6] = 16'h0000; rf[7] = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.instr       = 16'h0000;
        bus.wb_ready    = 1'b1;

        // reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_rdy",  bus.instr_ready, 1);
        chk("rst_vld",  bus.wb_valid, 0);
        chk("rst_ill",  bus.illegal, 0);
        chk("rst_cnt",  bus.ops_done, 0);
        chk("rst_a",    bus.bw_a, 0);
        chk("rst_fn",   bus.bw_funct, 0);
        chk("rst_wbd",  bus.wb_data, 0);
        chk("rst_addr", {bus.rs_addr, bus.rt_addr, bus.wb_addr}, 0);
`ifdef BITWISE_FLAGS_EN
        chk("rst_flags", {bus.flag_z, bus.flag_n}, 2'b00);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // AND r1&r2 -> r3
        issue(mk(4'b0010, 3'd3, 3'd1, 3'd2, 2'b00));
        wait_wb(k);
        chk("and_lat",  k, 3);
        chk("and_addr", bus.wb_addr, 3);
        chk("and_data", bus.wb_data, 16'h3030);
        chk("and_ops",  {bus.bw_a, bus.bw_b}, {16'hF0F0, 16'h3C3C});
        chk("and_rdy",  bus.instr_ready, 0);
        @(negedge clk);
        chk("and_cnt",  bus.ops_done, 1);
        chk("and_idle", {bus.instr_ready, bus.wb_valid}, 2'b10);

        // NOT r4 (rt=r2 still loaded into bw_b)
        issue(mk(4'b0010, 3'd5, 3'd4, 3'd2, 2'b11));
        wait_wb(k);
        chk("not_data", bus.wb_data, 16'hFF00);
        chk("not_b",    bus.bw_b, 16'h3C3C);
        chk("not_fn",   bus.bw_funct, 2'b11);
        @(negedge clk);
        chk("not_cnt",  bus.ops_done, 2);
`ifdef BITWISE_FLAGS_EN
        chk("not_flags", {bus.flag_z, bus.flag_n}, 2'b01);
`endif

        // XOR r4^r4 -> 0
        op("xor", mk(4'b0010, 3'd6, 3'd4, 3'd4, 2'b10), 3'd6, 16'h0000, 4'd3);
`ifdef BITWISE_FLAGS_EN
        chk("xor_flags", {bus.flag_z, bus.flag_n}, 2'b10);
`endif

        // backpressure: OR r1|r2 -> r7, wb_ready low for 5 cycles
        bus.wb_ready = 1'b0;
        issue(mk(4'b0010, 3'd7, 3'd1, 3'd2, 2'b01));
        wait_wb(k);
        chk("bp_lat", k, 3);
        repeat (5) begin
            @(negedge clk);
            chk("bp_vld",  bus.wb_valid, 1);
            chk("bp_data", bus.wb_data, 16'hFCFC);
            chk("bp_addr", bus.wb_addr, 7);
            chk("bp_rdy",  bus.instr_ready, 0);
            chk("bp_cnt",  bus.ops_done, 3);
        end
        bus.wb_ready = 1'b1;
        @(negedge clk);
        chk("bp_cnt2", bus.ops_done, 4);
        chk("bp_idle", {bus.instr_ready, bus.wb_valid}, 2'b10);

        // illegal opcode
        issue(mk(4'b0001, 3'd3, 3'd1, 3'd2, 2'b00));
        @(negedge clk);
        chk("ill_pulse", {bus.illegal, bus.wb_valid, bus.instr_ready}, 3'b100);
        @(negedge clk);
        chk("ill_end",   {bus.illegal, bus.wb_valid, bus.instr_ready}, 3'b001);
        chk("ill_cnt",   bus.ops_done, 4);

        // rd=0: OR r4|r4 completes without write-back
        issue(mk(4'b0010, 3'd0, 3'd4, 3'd4, 2'b01));
        repeat (3) begin
            @(negedge clk);
            chk("r0_vld", bus.wb_valid, 0);
        end
        chk("r0_rdy", bus.instr_ready, 1);
        chk("r0_cnt", bus.ops_done, 4);
`ifdef BITWISE_FLAGS_EN
        @(negedge clk);
        chk("r0_flags", {bus.flag_z, bus.flag_n}, 2'b00);
`endif

        // reset while stalled in WB
        bus.wb_ready = 1'b0;
        issue(mk(4'b0010, 3'd3, 3'd1, 3'd2, 2'b00));
        wait_wb(k);
        chk("mrst_lat", k, 3);
        #2 rst = 1'b1;
        #1;
        chk("mrst_vld", bus.wb_valid, 0);
        chk("mrst_wbd", bus.wb_data, 0);
        chk("mrst_cnt", bus.ops_done, 0);
        chk("mrst_rdy", bus.instr_ready, 1);
        chk("mrst_regs", {bus.bw_a, bus.wb_addr, bus.rs_addr}, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.wb_ready = 1'b1;
        @(negedge clk);
        chk("mrst_quiet", {bus.wb_valid, bus.instr_ready}, 2'b01);

        // saturation of the 4-bit counter
        for (int i = 1; i <= 17; i++) begin
            issue(mk(4'b0010, 3'd3, 3'd1, 3'd2, 2'b00));
            wait_wb(k);
            @(negedge clk);
            if (i == 14) chk("sat14", bus.ops_done, 4'hE);
            if (i == 15) chk("sat15", bus.ops_done, 4'hF);
        end
        chk("sat17", bus.ops_done, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
